// File: rtl/parity_pkg.sv
//------------------------------------------------------------------------------
// Module   : parity_pkg
// Purpose  : State encoding and parity constants shared by the serial parity receiver.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // XOR over data plus parity bit that a clean even-parity frame yields
    localparam logic PARITY_EVEN = 1'b0;

endpackage

`default_nettype wire

// File: rtl/parity_xor.sv
//------------------------------------------------------------------------------
// Module   : parity_xor
// Purpose  : XOR reduction over WIDTH bits; the same function as the parity generator.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module parity_xor #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] bits,
    output logic             check
);

    assign check = ^bits;

endmodule

`default_nettype wire

// File: rtl/parity_rx.sv
//------------------------------------------------------------------------------
// Module   : parity_rx
// Purpose  : Strobe-qualified serial deframer with even-parity and stop-bit checking.
//            Define PARITY_RX_ERRCNT_EN to add the saturating bad-frame counter err_cnt.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module parity_rx
    import parity_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
`ifdef PARITY_RX_ERRCNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    // A 1-bit index is kept even for DATA_W=1 so the counter never has zero width
    localparam int              IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    rx_state_t         state;
    rx_state_t         state_n;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shift;
    logic              par_bit;
    logic              check;
    logic              stop_edge;

    parity_xor #(
        .WIDTH (DATA_W + 1)
    ) u_parity_xor (
        .bits  ({par_bit, shift}),
        .check (check)
    );

    assign stop_edge = bit_en && (state == STOP);

    always_comb begin
        state_n = state;
        if (bit_en) begin
            case (state)
                IDLE:    if (!rx) state_n = DATA;
                DATA:    if (idx == LAST_IDX) state_n = PARITY;
                PARITY:  state_n = STOP;
                STOP:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= stop_edge;
            busy  <= (state_n != IDLE);
            if (bit_en) begin
                case (state)
                    IDLE: idx <= '0;
                    DATA: begin
                        shift[idx] <= rx;
                        idx        <= idx + 1'b1;
                    end
                    PARITY: par_bit <= rx;
                    STOP: begin
                        data_out   <= shift;
                        parity_err <= (check != PARITY_EVEN);
                        frame_err  <= ~rx;
                    end
                    default: idx <= '0;
                endcase
            end
        end
    end

`ifdef PARITY_RX_ERRCNT_EN
    logic frame_bad;

    // Updated on the stop edge so err_cnt already includes the frame while valid is high
    assign frame_bad = (check != PARITY_EVEN) | ~rx;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (stop_edge && frame_bad && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_parity_rx.sv
//------------------------------------------------------------------------------
// Module   : tb_parity_rx
// Purpose  : Directed-vector scoreboard bench for parity_rx (DATA_W=4).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_parity_rx;

    localparam int DATA_W = 4;
`ifdef PARITY_RX_ERRCNT_EN
    localparam int ERR_CNT_W = 2;
`else
    localparam int ERR_CNT_W = 8;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              rx;
    logic              bit_en;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;
`ifdef PARITY_RX_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt;
`endif

    parity_rx #(
        .DATA_W    (DATA_W),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .bit_en     (bit_en),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef PARITY_RX_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0]    data;
        logic                 pe;
        logic                 fe;
        logic                 use_cnt;
        logic [ERR_CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap idle cycles with garbage on rx, then one strobed bit
    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            bit_en = 1'b0;
            rx     = 1'($urandom);
            tick();
        end
        bit_en = 1'b1;
        rx     = b;
        tick();
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s,
                              input int gap, input logic ep, input logic ef,
                              input logic uc, input logic [ERR_CNT_W-1:0] ec);
        exp_t e;
        e.data = d; e.pe = ep; e.fe = ef; e.use_cnt = uc; e.cnt = ec;
        sb.push_back(e);
        send_bit(1'b0, gap);
        chk("busy_rise", 32'(busy), 32'd1);
        for (int i = 0; i < DATA_W; i++) send_bit(d[i], gap);
        send_bit(p, gap);
        send_bit(s, gap);
        chk("valid_latency", 32'(valid), 32'd1);
        chk("busy_fall", 32'(busy), 32'd0);
    endtask

    task automatic idle(input int n);
        bit_en = 1'b0;
        rx     = 1'b1;
        repeat (n) tick();
    endtask

    // Monitor: every valid pops one expected frame
    always @(negedge clk) begin
        if (valid) begin
            chk("valid_one_cycle", 32'(prev_valid), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("data_out", 32'(data_out), 32'(e.data));
                chk("parity_err", 32'(parity_err), 32'(e.pe));
                chk("frame_err", 32'(frame_err), 32'(e.fe));
`ifdef PARITY_RX_ERRCNT_EN
                if (e.use_cnt) chk("err_cnt", 32'(err_cnt), 32'(e.cnt));
`endif
            end
        end
        prev_valid = valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; rx = 1'b1; bit_en = 1'b0;
        repeat (3) tick();
        bit_en = 1'b1; rx = 1'b0;
        tick();
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef PARITY_RX_ERRCNT_EN
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        rst = 1'b0;
        idle(2);

        // Back-to-back frames with bit_en held high
        send_frame(4'hB, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, '0);
        send_frame(4'h6, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, '0);
        send_frame(4'h3, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, '0);
        idle(3);
        // Strobe every 3rd cycle with garbage between strobes
        send_frame(4'hB, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0, '0);
        idle(5);
        chk("hold_data_out", 32'(data_out), 32'hB);
        chk("hold_parity_err", 32'(parity_err), 32'd0);
        chk("hold_frame_err", 32'(frame_err), 32'd0);

        // Abort after two data bits
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        rst = 1'b1; bit_en = 1'b1; rx = 1'b0;
        tick();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_data_out", 32'(data_out), 32'd0);
        tick();
        rst = 1'b0;
        idle(2);
        send_frame(4'h5, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, '0);
        idle(3);

`ifdef PARITY_RX_ERRCNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(2);
        send_frame(4'h6, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1, 2'd1);
        send_frame(4'h6, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1, 2'd2);
        send_frame(4'h6, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1, 2'd3);
        send_frame(4'h6, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1, 2'd3);
        send_frame(4'h6, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1, 2'd3);
        send_frame(4'hB, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 2'd3);
        idle(2);
        rst = 1'b1;
        tick();
        chk("errcnt_rst", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        idle(2);
`endif

        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
